// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types for the data-memory port arbiter.
//   owner_e      : which port a returning read belongs to
//   arb_state_e  : arbitration priority state
//   arb_status_t : registered FSM context (priority state + pending read owner),
//                  kept as one struct so the FSM state is easy to probe
//   WORD_MASK    : byte-offset bits of a word address
//   is_misaligned: true when any byte-offset bit of an address is set
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    typedef enum logic {
        PRIO_CORE = 1'b0,
        PRIO_DBG  = 1'b1
    } arb_state_e;

    typedef struct packed {
        arb_state_e state;
        owner_e     rd_owner;
    } arb_status_t;

    localparam logic [1:0] WORD_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr
//   Counts consecutive arbitration losses of the debug port.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   inc  : debug port lost a conflict this cycle
//   clr  : debug port was granted (or the streak is otherwise broken)
//   hit  : count has reached LIMIT-1; the next loss must hand priority over
//   The count saturates at LIMIT-1; clr wins over inc.
module arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int unsigned   CW  = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [CW-1:0] TOP = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !hit) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign hit = (cnt_q == TOP);

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares a single-port data memory between the core load/store port and a
//   debug/loader port. The core has fixed priority, but after STARVE_LIMIT
//   consecutive lost conflicts the debug port is given one guaranteed cycle.
//
//   Handshake: a requester holds *_req (and its command fields) until it sees
//   *_gnt high in the same cycle; the access is issued to memory in that
//   cycle. Loads return one cycle later with *_rvalid for exactly one cycle.
//   Writes have no response.
//
//   Ports
//     clk, Reset                     clock, asynchronous active-high reset
//     core_req/we/addr/wdata         core request (held until granted)
//     core_gnt, core_stall           grant / core_req without grant
//     core_rvalid, core_rdata        core load return
//     core_err                       misaligned core access (consumed, not issued)
//     dbg_req/we/addr/wdata          debug request (addr[1:0] ignored)
//     dbg_gnt, dbg_rvalid, dbg_rdata debug grant and read return
//     mem_en/we/addr/wdata           memory command
//     mem_rdata                      memory read data, one cycle after a read
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_err,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] DBG_ADDR_MASK = ~ADDR_W'(WORD_MASK);

    arb_status_t status_q, status_d;

    logic core_mis;
    logic core_val;
    logic core_win;
    logic dbg_win;
    logic cnt_inc;
    logic cnt_clr;
    logic starve_hit;

    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    // A misaligned core request is consumed with an error and never reaches
    // memory, so for arbitration it looks exactly like an idle core.
    assign core_mis = core_req && is_misaligned(core_addr[1:0]);
    assign core_val = core_req && !core_mis;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk (clk),
        .rst (Reset),
        .inc (cnt_inc),
        .clr (cnt_clr),
        .hit (starve_hit)
    );

    // FSM state and pending-read owner
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            status_q <= '{state: PRIO_CORE, rd_owner: OWN_NONE};
        end else begin
            status_q <= status_d;
        end
    end

    // Next state, winner selection and counter control. Grants are gated
    // while Reset is high so every output reads 0 during reset.
    always_comb begin
        status_d          = status_q;
        status_d.rd_owner = OWN_NONE;
        core_win          = 1'b0;
        dbg_win           = 1'b0;
        cnt_inc           = 1'b0;
        cnt_clr           = 1'b0;

        if (!Reset) begin
            case (status_q.state)
                PRIO_CORE: begin
                    if (core_val) begin
                        core_win = 1'b1;
                        if (dbg_req) begin
                            cnt_inc = 1'b1;
                            if (starve_hit) begin
                                status_d.state = PRIO_DBG;
                            end
                        end
                    end else if (dbg_req) begin
                        dbg_win = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
                PRIO_DBG: begin
                    // One forced debug slot; if debug already withdrew,
                    // the core gets the slot instead. Either way the
                    // starvation streak is over.
                    status_d.state = PRIO_CORE;
                    cnt_clr        = 1'b1;
                    if (dbg_req) begin
                        dbg_win = 1'b1;
                    end else if (core_val) begin
                        core_win = 1'b1;
                    end
                end
                default: begin
                    status_d.state = PRIO_CORE;
                end
            endcase

            if (dbg_win && !dbg_we) begin
                status_d.rd_owner = OWN_DBG;
            end else if (core_win && !core_we) begin
                status_d.rd_owner = OWN_CORE;
            end
        end
    end

    // Memory command mux from the winning port
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dbg_win) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr & DBG_ADDR_MASK;
            mem_wdata = dbg_wdata;
        end else if (core_win) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    assign core_err   = core_mis && !Reset;
    assign core_gnt   = core_win || core_err;
    assign core_stall = core_req && !core_gnt && !Reset;
    assign dbg_gnt    = dbg_win;

    // Read return: the owner of the read issued last cycle sees mem_rdata
    // directly; the other port keeps showing its last returned word.
    assign core_rvalid = (status_q.rd_owner == OWN_CORE);
    assign dbg_rvalid  = (status_q.rd_owner == OWN_DBG);
    assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
    assign dbg_rdata   = dbg_rvalid ? mem_rdata : dbg_rdata_q;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            if (core_rvalid) begin
                core_rdata_q <= mem_rdata;
            end
            if (dbg_rvalid) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

endmodule
